// File: rtl/song_sequencer.sv
// Song sequencer: frame ticks -> beats -> pattern ROM fetch.
// Drives note selects, decaying envelopes and the kick sweep.
module song_sequencer #(
  parameter int          SONG_LEN       = 288,
  parameter int          TICKS_PER_BEAT = 6,
  parameter logic [8:0]  KICK_START     = 9'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_strobe,
  input  logic        run,
  input  logic        restart,
  output logic [8:0]  rom_addr,
  input  logic [12:0] rom_data,
  output logic [8:0]  songpos,
  output logic        beat,
  output logic [2:0]  mel_note,
  output logic [1:0]  mel_oct,
  output logic [2:0]  bass_note,
  output logic [1:0]  bass_oct,
  output logic [5:0]  sqr_vol,
  output logic [5:0]  bass_vol,
  output logic        kick_on,
  output logic [8:0]  kick_inc
);

  localparam int TW = $clog2(TICKS_PER_BEAT + 1);
  localparam logic [8:0] LAST = 9'(SONG_LEN - 1);
  localparam logic [TW-1:0] TPB = TW'(TICKS_PER_BEAT);

  logic [TW-1:0] tick_ctr;
  logic [TW-1:0] tick_nxt;
  logic          load_pend;
  logic          tick_pend;
  logic          tick_go;
  logic          beat_go;
  logic [1:0]    kick_ctr;
  logic [8:0]    pos_nxt;
  logic [5:0]    sqr_dec;
  logic [5:0]    bass_dec;
  logic [8:0]    kick_dec;

  assign rom_addr = songpos;
  assign kick_on  = (kick_ctr != 2'd0);

  always_comb begin
    tick_go  = (tick_strobe | tick_pend) & ~load_pend;
    tick_nxt = tick_ctr + 1'b1;
    beat_go  = tick_go & run & (tick_nxt == TPB);
    pos_nxt  = (songpos == LAST) ? 9'd0 : songpos + 9'd1;
    sqr_dec  = sqr_vol - (sqr_vol >> 3);
    bass_dec = bass_vol - (bass_vol >> 2);
    kick_dec = kick_inc - (kick_inc >> 3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      songpos   <= LAST;
      tick_ctr  <= '0;
      load_pend <= 1'b0;
      tick_pend <= 1'b0;
      beat      <= 1'b0;
      mel_note  <= '0;
      mel_oct   <= '0;
      bass_note <= '0;
      bass_oct  <= '0;
      sqr_vol   <= '0;
      bass_vol  <= '0;
      kick_ctr  <= '0;
      kick_inc  <= '0;
    end else if (restart) begin
      songpos   <= LAST;
      tick_ctr  <= '0;
      load_pend <= 1'b0;
      tick_pend <= 1'b0;
      beat      <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (load_pend) begin
        load_pend <= 1'b0;
        // a frame tick landing on the fetch cycle is deferred
        tick_pend <= tick_pend | tick_strobe;
        mel_note  <= rom_data[2:0];
        mel_oct   <= rom_data[4:3];
        bass_note <= rom_data[8:6];
        bass_oct  <= rom_data[10:9];
        if (rom_data[5])
          sqr_vol <= 6'd63;
        if (rom_data[11])
          bass_vol <= 6'd63;
        if (rom_data[12]) begin
          kick_ctr <= 2'd1;
          kick_inc <= KICK_START;
        end
      end else if (tick_go) begin
        tick_pend <= tick_pend & tick_strobe;
        if (beat_go) begin
          tick_ctr  <= '0;
          songpos   <= pos_nxt;
          beat      <= 1'b1;
          load_pend <= 1'b1;
        end else begin
          if (run)
            tick_ctr <= tick_nxt;
          sqr_vol  <= sqr_dec;
          bass_vol <= bass_dec;
          if (kick_ctr != 2'd0) begin
            kick_ctr <= kick_ctr + 2'd1;
            kick_inc <= kick_dec;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed tables, corner sequences,
// and random ticks against an event-level reference model.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_strobe;
  logic        run;
  logic        restart;
  logic [8:0]  rom_addr;
  logic [12:0] rom_data;
  logic [8:0]  songpos;
  logic        beat;
  logic [2:0]  mel_note;
  logic [1:0]  mel_oct;
  logic [2:0]  bass_note;
  logic [1:0]  bass_oct;
  logic [5:0]  sqr_vol;
  logic [5:0]  bass_vol;
  logic        kick_on;
  logic [8:0]  kick_inc;

  logic [12:0] rom [0:287];

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  song_sequencer dut (
    .clk(clk), .reset(reset), .tick_strobe(tick_strobe),
    .run(run), .restart(restart), .rom_addr(rom_addr),
    .rom_data(rom_data), .songpos(songpos), .beat(beat),
    .mel_note(mel_note), .mel_oct(mel_oct),
    .bass_note(bass_note), .bass_oct(bass_oct),
    .sqr_vol(sqr_vol), .bass_vol(bass_vol),
    .kick_on(kick_on), .kick_inc(kick_inc)
  );

  typedef struct {
    int sqr;
    int bass;
    int kon;
    int kinc;
  } env_t;

  env_t tab [6];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input logic ts);
    tick_strobe = ts;
    @(posedge clk);
    #1;
    tick_strobe = 1'b0;
  endtask

  task automatic tick();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
  endtask

  task automatic ticks_to_beat(output int k);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1);
      if (beat) begin
        k = i;
        cyc(1'b0);
        break;
      end
      cyc(1'b0);
    end
  endtask

  // reference model: event level, counts queued ticks
  int m_pos, m_ticks, m_backlog, m_sqr, m_bass;
  int m_kph, m_kinc, m_notes, m_beat;
  bit m_fetch;

  task automatic m_init();
    m_pos = 287; m_ticks = 0; m_backlog = 0; m_fetch = 0;
    m_sqr = 0; m_bass = 0; m_kph = 0; m_kinc = 0;
    m_notes = 0; m_beat = 0;
  endtask

  task automatic m_step(input bit ts, input bit rn, input bit rs);
    int w;
    if (rs) begin
      m_pos = 287; m_ticks = 0; m_fetch = 0;
      m_backlog = 0; m_beat = 0;
      return;
    end
    m_beat = 0;
    if (m_fetch) begin
      w = int'(rom[m_pos]);
      m_fetch = 0;
      m_backlog += int'(ts);
      m_notes = ((w % 8) << 7) | (((w / 8) % 4) << 5)
              | (((w / 64) % 8) << 2) | ((w / 512) % 4);
      if ((w / 32) % 2 == 1) m_sqr = 63;
      if ((w / 2048) % 2 == 1) m_bass = 63;
      if ((w / 4096) % 2 == 1) begin
        m_kph = 1;
        m_kinc = 384;
      end
    end else if (m_backlog + int'(ts) > 0) begin
      m_backlog = m_backlog + int'(ts) - 1;
      if (rn && m_ticks == 5) begin
        m_ticks = 0;
        m_pos = (m_pos + 1) % 288;
        m_beat = 1;
        m_fetch = 1;
      end else begin
        if (rn) m_ticks++;
        m_sqr = m_sqr - m_sqr / 8;
        m_bass = m_bass - m_bass / 4;
        if (m_kph != 0) begin
          m_kph = (m_kph + 1) % 4;
          m_kinc = m_kinc - m_kinc / 8;
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb, at, k, wraps, bad, prev;
    bit ts, rn, rs, pts;

    tab[0] = '{63, 63, 1, 'h180};
    tab[1] = '{56, 48, 1, 'h150};
    tab[2] = '{49, 36, 1, 'h126};
    tab[3] = '{43, 27, 0, 'h102};
    tab[4] = '{38, 21, 0, 'h102};
    tab[5] = '{34, 16, 0, 'h102};

    for (int i = 0; i < 288; i++) rom[i] = '0;
    rom[0] = 13'h1FFF;
    reset = 1'b1;
    run = 1'b1;
    restart = 1'b0;
    tick_strobe = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    chk("rst_songpos", songpos, 287);
    chk("rst_rom_addr", rom_addr, 287);
    chk("rst_beat", beat, 0);
    chk("rst_sqr", sqr_vol, 0);
    chk("rst_bass", bass_vol, 0);
    chk("rst_kick_on", kick_on, 0);
    chk("rst_kick_inc", kick_inc, 0);
    chk("rst_notes", {mel_note, mel_oct, bass_note, bass_oct}, 0);

    // first beat on the sixth tick
    nb = 0;
    at = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1);
      if (beat) begin
        nb++;
        at = i;
      end
      if (i < 6) begin
        cyc(1'b0);
        if (beat) nb++;
      end
    end
    chk("beat_count", nb, 1);
    chk("beat_tick", at, 6);
    chk("first_songpos", songpos, 0);
    chk("pre_fetch_sqr", sqr_vol, 0);
    cyc(1'b0);
    chk("mel_note", mel_note, 7);
    chk("mel_oct", mel_oct, 3);
    chk("bass_note", bass_note, 7);
    chk("bass_oct", bass_oct, 3);
    chk("beat_clear", beat, 0);

    // envelope decay table
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk($sformatf("sqr_%0d", i), sqr_vol, tab[i].sqr);
      chk($sformatf("bass_%0d", i), bass_vol, tab[i].bass);
      chk($sformatf("kon_%0d", i), kick_on, tab[i].kon);
      chk($sformatf("kinc_%0d", i), kick_inc, tab[i].kinc);
    end

    // tick colliding with the fetch cycle
    rom[1] = 13'h02B5;
    cyc(1'b1);
    chk("col_beat", beat, 1);
    chk("col_songpos", songpos, 1);
    cyc(1'b1);
    chk("col_notes", {mel_note, mel_oct, bass_note, bass_oct},
        {3'd5, 2'd2, 3'd2, 2'd1});
    chk("col_sqr_trig", sqr_vol, 63);
    chk("col_bass_keep", bass_vol, 16);
    cyc(1'b0);
    chk("col_sqr_dec", sqr_vol, 56);
    chk("col_bass_dec", bass_vol, 12);
    cyc(1'b0);
    chk("col_once", sqr_vol, 49 + 0 * int'(beat) + 7);
    ticks_to_beat(k);
    chk("col_next_beat", k, 5);
    chk("col_next_pos", songpos, 2);

    // run low: counting frozen, envelopes decay to floor
    rom[0] = 13'h0020;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    chk("rl_sqr_start", sqr_vol, 63);
    run = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("rl_songpos", songpos, 0);
    chk("rl_sqr_floor", sqr_vol, 7);
    tick();
    chk("rl_sqr_stall", sqr_vol, 7);
    run = 1'b1;
    ticks_to_beat(k);
    chk("rl_tick_frozen", k, 6);
    chk("rl_pos_after", songpos, 1);

    // restart mid-song together with a tick
    restart = 1'b1;
    cyc(1'b0);
    restart = 1'b0;
    for (int i = 0; i < 609; i++) tick();
    chk("mid_songpos", songpos, 100);
    restart = 1'b1;
    cyc(1'b1);
    restart = 1'b0;
    chk("rs_songpos", songpos, 287);
    chk("rs_sqr_keep", sqr_vol, 7);
    cyc(1'b0);
    ticks_to_beat(k);
    chk("rs_next_beat", k, 6);
    chk("rs_pos0", songpos, 0);

    // full song wrap
    restart = 1'b1;
    cyc(1'b0);
    restart = 1'b0;
    wraps = 0;
    bad = 0;
    for (int i = 0; i < 1728; i++) begin
      prev = songpos;
      cyc(1'b1);
      if (prev == 287 && songpos == 0) wraps++;
      if (rom_addr != songpos) bad++;
      cyc(1'b0);
    end
    chk("wrap_count", wraps, 1);
    chk("wrap_addr", bad, 0);
    chk("wrap_end_pos", songpos, 287);

    // reset while the fetch is pending
    rom[0] = 13'h1FFF;
    for (int i = 0; i < 5; i++) tick();
    cyc(1'b1);
    chk("rf_beat", beat, 1);
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    chk("rf_songpos", songpos, 287);
    chk("rf_beat_low", beat, 0);
    cyc(1'b0);
    chk("rf_sqr", sqr_vol, 0);
    chk("rf_kick", kick_on, 0);
    chk("rf_notes", {mel_note, mel_oct, bass_note, bass_oct}, 0);

    // random ticks against the model
    for (int i = 0; i < 288; i++) rom[i] = 13'($urandom);
    do_reset();
    m_init();
    pts = 0;
    for (int c = 0; c < 3000; c++) begin
      ts = !pts && ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 199) == 0);
      pts = ts;
      tick_strobe = ts;
      run = rn;
      restart = rs;
      @(posedge clk);
      m_step(ts, rn, rs);
      #1;
      tick_strobe = 1'b0;
      restart = 1'b0;
      chk("rnd_songpos", songpos, m_pos);
      chk("rnd_beat", beat, m_beat);
      chk("rnd_sqr", sqr_vol, m_sqr);
      chk("rnd_bass", bass_vol, m_bass);
      chk("rnd_kick_on", kick_on, int'(m_kph != 0));
      chk("rnd_kick_inc", kick_inc, m_kinc);
      chk("rnd_notes", {mel_note, mel_oct, bass_note, bass_oct},
          m_notes);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Music sequencer that sits directly upstream of the square/bass/kick synth voices and the PWM audio path.
- Counts frame ticks into beats and steps a song position through a pattern ROM.
- Fetches each beat's packed note word with a one-cycle ROM latency.
- Outputs per-voice note/octave selects plus decaying volume envelopes and the kick pitch sweep that the synth consumes every scanline.

Parameters:
- SONG_LEN, 288, number of pattern steps; songpos wraps SONG_LEN-1 -> 0.
- TICKS_PER_BEAT, 6, frame ticks per beat.
- KICK_START, 9'h180, kick oscillator increment loaded on kick trigger.

Ports:
- clk  input  1  system clock (pixel clock).
- reset  input  1  synchronous active-high reset.
- tick_strobe  input  1  one-cycle pulse per frame (pix_x==0 && pix_y==0).
- run  input  1  1 = sequencer advances; 0 = ticks ignored for counting, envelopes still decay.
- restart  input  1  one-cycle pulse: rewind song to start.
- rom_addr  output  9  pattern ROM address; equals songpos.
- rom_data  input  13  pattern word, valid one cycle after rom_addr changes. Fields: [12] kick_trig, [11] bass_trig, [10:9] bass_oct, [8:6] bass_note, [5] mel_trig, [4:3] mel_oct, [2:0] mel_note.
- songpos  output  9  current song step.
- beat  output  1  one-cycle pulse in the cycle songpos advances.
- mel_note  output  3  latched melody note.
- mel_oct  output  2  latched melody octave.
- bass_note  output  3  latched bass note.
- bass_oct  output  2  latched bass octave.
- sqr_vol  output  6  melody envelope.
- bass_vol  output  6  bass envelope.
- kick_on  output  1  kick active (kick_ctr != 0).
- kick_inc  output  9  kick oscillator increment.

Behaviour:
- Synchronous reset:
  - songpos = SONG_LEN-1, tick_ctr = 0.
  - load_pend = 0, tick_pend = 0.
  - all note/oct regs 0.
  - sqr_vol = bass_vol = 0.
  - kick_ctr = 0, kick_inc = 0, beat = 0.
  - reset takes priority over every other input, including mid-fetch.
- Tick processing, on tick_strobe (or tick_pend) with load_pend = 0:
  - Envelope decay each tick, including when run = 0:
    - sqr_vol <= sqr_vol - (sqr_vol>>3).
    - bass_vol <= bass_vol - (bass_vol>>2).
    - if kick_ctr != 0: kick_ctr <= kick_ctr+1 (2-bit; wraps to 0 = off) and kick_inc <= kick_inc - (kick_inc>>3).
  - If run = 1:
    - tick_ctr_next = tick_ctr+1.
    - If tick_ctr_next == TICKS_PER_BEAT: tick_ctr <= 0; songpos <= (songpos == SONG_LEN-1) ? 0 : songpos+1; beat <= 1; load_pend <= 1. Envelope decay is skipped on a beat tick.
    - Otherwise tick_ctr <= tick_ctr_next.
- Fetch: rom_addr = songpos, combinational from the register. In the cycle load_pend = 1:
  - latch all note/oct fields from rom_data.
  - mel_trig -> sqr_vol <= 63.
  - bass_trig -> bass_vol <= 63.
  - kick_trig -> kick_ctr <= 1, kick_inc <= KICK_START.
  - non-triggered voices keep their current envelope values.
  - clear load_pend.
- Collision: a tick_strobe arriving while load_pend = 1 sets tick_pend and is processed the following cycle. No tick is ever lost.
- restart (reset excluded):
  - songpos <= SONG_LEN-1, tick_ctr <= 0, load_pend <= 0, tick_pend <= 0.
  - envelopes and notes are untouched.
  - restart wins over a simultaneous tick.
- Latency:
  - beat is high one cycle after the tick.
  - Note and volume outputs update two cycles after the tick.
- First beat after reset/restart occurs on the TICKS_PER_BEAT-th tick, with songpos = 0.
- Arithmetic: all decay arithmetic is unsigned. Volumes never underflow; 7>>3 = 0, so sqr_vol stalls at 7, and bass_vol stalls at 3.

Test Plan:
- Reset, run=1, ROM[0]=13'h1FFF, 6 ticks -> beat pulses once on tick 6. songpos 287->0. Two cycles later: sqr_vol=63, bass_vol=63, kick_on=1, kick_inc=0x180, mel_note=7, bass_oct=3.
- Continue 5 ticks after the trigger -> sqr_vol 63,56,49,43,38,34. bass_vol 63,48,36,27,21,16. kick_ctr 1,2,3,0 (kick_on low after 3 ticks), kick_inc 0x180->0x150->0x126->0x102.
- Run 288*6 ticks -> songpos wraps 287->0 exactly once per 1728 ticks. rom_addr tracks songpos.
- tick_strobe pulsed in the cycle right after a beat tick (load_pend=1) -> ROM word still latched. The deferred tick is processed the next cycle: tick_ctr=1, decay applied once.
- run=0 for 20 ticks with sqr_vol=63 -> songpos and tick_ctr frozen. sqr_vol decays to its floor (7).
- restart mid-song (songpos=100, tick_ctr=3) together with a tick -> songpos=287, tick_ctr=0. The next beat comes 6 ticks later at songpos 0. Reset asserted during load_pend -> all outputs return to reset values with no latch.
